stripe_detector: RTL and testbench

STRIPE_DETECTOR -- requirements
Module: stripe_detector

---
 rtl/pacey_vision_pkg.sv | 31 +++
 rtl/pixel_classifier.sv | 29 ++
 rtl/stripe_detector.sv | 101 ++++++++++
 tb/tb_stripe_detector.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pacey_vision_pkg.sv
// rtl/pacey_vision_pkg.sv - shared pixel class, run FSM state and helpers for stripe detection
package pacey_vision_pkg;

    localparam int PIX_W = 8;

    typedef enum logic [1:0] {
        CLS_NONE  = 2'd0,
        CLS_WHITE = 2'd1,
        CLS_BLACK = 2'd2
    } pix_class_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUN_WHITE = 2'd1,
        ST_RUN_BLACK = 2'd2,
        ST_RUN_NONE  = 2'd3
    } run_state_t;

    function automatic run_state_t state_of_class(input pix_class_t c);
        case (c)
            CLS_WHITE: return ST_RUN_WHITE;
            CLS_BLACK: return ST_RUN_BLACK;
            default:   return ST_RUN_NONE;
        endcase
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/pixel_classifier.sv
// rtl/pixel_classifier.sv - combinational white/black/none classification of one pixel
module pixel_classifier
    import pacey_vision_pkg::*;
#(
    parameter logic [PIX_W-1:0] WHITE_MIN = 8'd200,
    parameter logic [PIX_W-1:0] BLACK_MAX = 8'd50
) (
    input  logic [PIX_W-1:0] red,
    input  logic [PIX_W-1:0] green,
    input  logic [PIX_W-1:0] blue,
    output pix_class_t       cls
);

    logic is_white;
    logic is_black;

    always_comb begin
        is_white = (red >= WHITE_MIN) && (green >= WHITE_MIN) && (blue >= WHITE_MIN);
        is_black = (red <= BLACK_MAX) && (green <= BLACK_MAX) && (blue <= BLACK_MAX);
        cls      = CLS_NONE;
        // white wins when a misconfiguration lets both tests pass
        if (is_white) begin
            cls = CLS_WHITE;
        end else if (is_black) begin
            cls = CLS_BLACK;
        end
    end

endmodule

// File: rtl/stripe_detector.sv
// rtl/stripe_detector.sv - detects qualified white/black runs per scanline and counts them per frame
module stripe_detector
    import pacey_vision_pkg::*;
#(
    parameter logic [PIX_W-1:0] WHITE_MIN = 8'd200,
    parameter logic [PIX_W-1:0] BLACK_MAX = 8'd50,
    parameter logic [7:0]       RUN_LEN   = 8'd8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pix_valid,
    input  logic             pix_sop,
    input  logic             pix_eol,
    input  logic [PIX_W-1:0] red,
    input  logic [PIX_W-1:0] green,
    input  logic [PIX_W-1:0] blue,
    output logic             white_detect,
    output logic             black_detect,
    output logic [7:0]       stripe_count
);

    pix_class_t cls;
    run_state_t state, state_next, state_eff;
    pix_class_t last_qual, last_next, last_eff;
    logic [7:0] run_cnt, run_cnt_next, cnt_eff;
    logic [7:0] count_next, count_eff;
    logic       white_next, black_next;
    logic       new_run, qualify;

    pixel_classifier #(
        .WHITE_MIN (WHITE_MIN),
        .BLACK_MAX (BLACK_MAX)
    ) u_classifier (
        .red   (red),
        .green (green),
        .blue  (blue),
        .cls   (cls)
    );

    always_comb begin
        state_next   = state;
        run_cnt_next = run_cnt;
        last_next    = last_qual;
        count_next   = stripe_count;
        white_next   = 1'b0;
        black_next   = 1'b0;
        state_eff    = state;
        cnt_eff      = run_cnt;
        last_eff     = last_qual;
        count_eff    = stripe_count;
        new_run      = 1'b0;
        qualify      = 1'b0;
        if (pix_valid) begin
            // sop clears the context before the pixel itself is processed
            if (pix_sop) begin
                state_eff = ST_IDLE;
                cnt_eff   = 8'd0;
                last_eff  = CLS_NONE;
                count_eff = 8'd0;
            end
            new_run      = (state_eff != state_of_class(cls));
            run_cnt_next = new_run ? 8'd1 : sat_inc8(cnt_eff);
            state_next   = state_of_class(cls);
            // a saturated counter staying at 255 must not re-qualify a RUN_LEN of 255
            qualify      = (cls != CLS_NONE) && (run_cnt_next == RUN_LEN) &&
                           (new_run || (cnt_eff != 8'hFF));
            last_next    = last_eff;
            count_next   = count_eff;
            if (qualify && (cls != last_eff)) begin
                white_next = (cls == CLS_WHITE);
                black_next = (cls == CLS_BLACK);
                last_next  = cls;
                count_next = sat_inc8(count_eff);
            end
            if (pix_eol) begin
                state_next   = ST_IDLE;
                run_cnt_next = 8'd0;
                last_next    = CLS_NONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            run_cnt      <= 8'd0;
            last_qual    <= CLS_NONE;
            white_detect <= 1'b0;
            black_detect <= 1'b0;
            stripe_count <= 8'd0;
        end else begin
            state        <= state_next;
            run_cnt      <= run_cnt_next;
            last_qual    <= last_next;
            white_detect <= white_next;
            black_detect <= black_next;
            stripe_count <= count_next;
        end
    end

endmodule

// File: tb/tb_stripe_detector.sv
// tb/tb_stripe_detector.sv - scoreboard bench for stripe_detector at RUN_LEN 8 and RUN_LEN 1
module tb_stripe_detector;

    logic       clk = 1'b0;
    logic       reset, pix_valid, pix_sop, pix_eol;
    logic [7:0] red, green, blue;
    logic       w8, b8, w1, b1;
    logic [7:0] c8, c1;

    always #5 clk = ~clk;

    stripe_detector #(.RUN_LEN(8'd8)) u_det8 (
        .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_sop(pix_sop), .pix_eol(pix_eol),
        .red(red), .green(green), .blue(blue),
        .white_detect(w8), .black_detect(b8), .stripe_count(c8)
    );

    stripe_detector #(.RUN_LEN(8'd1)) u_det1 (
        .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_sop(pix_sop), .pix_eol(pix_eol),
        .red(red), .green(green), .blue(blue),
        .white_detect(w1), .black_detect(b1), .stripe_count(c1)
    );

    int n_vec  = 0;
    int n_miss = 0;

    // reference model state per instance: 0 = RUN_LEN 8, 1 = RUN_LEN 1
    int m_cls[2], m_len[2], m_last[2], m_cnt[2];
    int rl[2] = '{8, 1};
    int wp[2] = '{0, 0};
    int bp[2] = '{0, 0};
    logic [31:0] q8[$];
    logic [31:0] q1[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int classify(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        if (r >= 200 && g >= 200 && b >= 200) return 1;
        if (r <= 50 && g <= 50 && b <= 50) return 2;
        return 0;
    endfunction

    task automatic model_step(input int i, input logic rst, input logic v, input logic sop,
                              input logic eol, input int cls, output logic [31:0] e);
        int w, b;
        w = 0;
        b = 0;
        if (rst) begin
            m_len[i]  = 0;
            m_last[i] = 0;
            m_cnt[i]  = 0;
        end else if (v) begin
            if (sop) begin
                m_len[i]  = 0;
                m_last[i] = 0;
                m_cnt[i]  = 0;
            end
            if (m_len[i] == 0 || cls != m_cls[i]) begin
                m_cls[i] = cls;
                m_len[i] = 1;
            end else begin
                m_len[i]++;
            end
            if (cls != 0 && m_len[i] == rl[i] && m_last[i] != cls) begin
                w = (cls == 1) ? 1 : 0;
                b = (cls == 2) ? 1 : 0;
                m_last[i] = cls;
                if (m_cnt[i] < 255) m_cnt[i]++;
            end
            if (eol) begin
                m_len[i]  = 0;
                m_last[i] = 0;
            end
        end
        e = (w << 9) | (b << 8) | m_cnt[i];
    endtask

    task automatic drive(input logic rst, input logic v, input logic sop, input logic eol,
                         input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        logic [31:0] e;
        @(negedge clk);
        reset = rst; pix_valid = v; pix_sop = sop; pix_eol = eol;
        red = r; green = g; blue = b;
        model_step(0, rst, v, sop, eol, classify(r, g, b), e);
        q8.push_back(e);
        model_step(1, rst, v, sop, eol, classify(r, g, b), e);
        q1.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic pixels(input int n, input int kind, input logic sop_first, input logic eol_last);
        logic [7:0] ch;
        ch = (kind == 1) ? 8'd255 : (kind == 2) ? 8'd10 : 8'd128;
        for (int k = 0; k < n; k++)
            drive(1'b0, 1'b1, sop_first && (k == 0), eol_last && (k == n - 1), ch, ch, ch);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            drive(1'b0, 1'b0, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    endtask

    initial begin : scoreboard
        logic [31:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (q8.size() > 0) begin
                e = q8.pop_front();
                check("det8_out", 32'({w8, b8, c8}), e);
                if (w8) wp[0]++;
                if (b8) bp[0]++;
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check("det1_out", 32'({w1, b1, c1}), e);
                if (w1) wp[1]++;
                if (b1) bp[1]++;
            end
        end
    end

    initial begin : stimulus
        int base_w, base_b, base_t;
        reset = 1'b1; pix_valid = 1'b0; pix_sop = 1'b0; pix_eol = 1'b0;
        red = 8'd0; green = 8'd0; blue = 8'd0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 8'd255, 8'd255, 8'd255);
        check("reset_state", 32'({w8, b8, c8}), 0);

        // single white run
        base_w = wp[0];
        pixels(7, 1, 1'b1, 1'b0);
        check("s1_no_pulse_at_7", 32'(w8), 0);
        pixels(1, 1, 1'b0, 1'b0);
        check("s1_pulse_at_8", 32'(w8), 1);
        check("s1_count", 32'(c8), 1);
        pixels(20, 1, 1'b0, 1'b0);
        check("s1_no_extra_pulse", wp[0] - base_w, 1);

        // alternating runs on one line
        base_w = wp[0]; base_b = bp[0];
        pixels(8, 1, 1'b1, 1'b0);
        pixels(8, 2, 1'b0, 1'b0);
        pixels(8, 1, 1'b0, 1'b0);
        check("s2_white_pulses", wp[0] - base_w, 2);
        check("s2_black_pulses", bp[0] - base_b, 1);
        check("s2_count", 32'(c8), 3);

        // none gap keeps last_qual, eol clears it
        base_w = wp[0];
        pixels(8, 1, 1'b1, 1'b0);
        pixels(3, 0, 1'b0, 1'b0);
        pixels(8, 1, 1'b0, 1'b1);
        check("s3_one_pulse", wp[0] - base_w, 1);
        pixels(8, 1, 1'b0, 1'b0);
        check("s3_next_line_pulse", wp[0] - base_w, 2);
        check("s3_count", 32'(c8), 2);

        // valid gaps hold the run
        base_w = wp[0];
        pixels(7, 1, 1'b1, 1'b0);
        idle(5);
        check("s4_gap_quiet", wp[0] - base_w, 0);
        pixels(1, 1, 1'b0, 1'b0);
        check("s4_pulse_after_gap", 32'(w8), 1);

        // mid-run reset discards the run, even with a qualifying pixel in the reset cycle
        pixels(7, 1, 1'b1, 1'b0);
        base_w = wp[0];
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'd255, 8'd255, 8'd255);
        pixels(1, 1, 1'b0, 1'b0);
        check("s5_no_pulse", wp[0] - base_w, 0);
        check("s5_count_cleared", 32'(c8), 0);
        pixels(7, 1, 1'b0, 1'b0);
        check("s5_pulse_after_8", wp[0] - base_w, 1);
        check("s5_count", 32'(c8), 1);

        // RUN_LEN 1 edge settings
        base_b = bp[1]; base_t = wp[1] + bp[1];
        drive(1'b0, 1'b1, 1'b1, 1'b1, 8'd10, 8'd10, 8'd10);
        check("s6_black_sop_eol", 32'(b1), 1);
        check("s6_count_one", 32'(c1), 1);
        for (int k = 0; k < 300; k++)
            pixels(1, (k % 2 == 0) ? 1 : 2, 1'b0, 1'b0);
        check("s6_count_saturated", 32'(c1), 255);
        check("s6_pulses", (wp[1] + bp[1]) - base_t, 301);
        check("s6_black_first", bp[1] - base_b, 151);

        idle(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
